// File: rtl/mem_stage.sv
// MEM stage: data-memory load/store from EX/MEM, MEM/WB pipeline register,
// combinational forwarding value and committed load/store counters.
module mem_stage #(
  parameter int unsigned DM_AW = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        flush,
  input  logic        dmld,
  input  logic        dmsel,
  input  logic        dmstr,
  input  logic [31:0] aluout,
  input  logic [31:0] rfd2,
  input  logic [31:0] pc,
  input  logic [31:0] IR,
  output logic [31:0] fwd_data,
  output logic        dmld_nxt,
  output logic [31:0] memout_nxt,
  output logic [31:0] aluout_nxt,
  output logic [31:0] pc_nxt,
  output logic [31:0] IR_nxt,
  output logic        misal_nxt,
  output logic [31:0] ld_cnt,
  output logic [31:0] st_cnt
);

  localparam int unsigned DEPTH = 1 << DM_AW;

  logic [31:0]      mem [DEPTH];
  logic [DM_AW-1:0] widx;
  logic [1:0]       lane;
  logic [31:0]      rd_word;
  logic [7:0]       rd_byte;
  logic [31:0]      ld_data;
  logic             is_ld;
  logic             cm;
  logic             misal;

  assign widx = aluout[DM_AW+1:2];
  assign lane = aluout[1:0];

  // A simultaneous load+store behaves as a store only; its load data is forced to zero.
  always_comb begin
    is_ld   = dmld & ~dmstr;
    cm      = en & ~flush & ~rst;
    misal   = (dmld | dmstr) & ~dmsel & (lane != 2'b00);
    rd_word = mem[widx];
    rd_byte = rd_word[{lane, 3'b000} +: 8];
    ld_data = '0;
    if (is_ld) ld_data = dmsel ? {{24{rd_byte[7]}}, rd_byte} : rd_word;
    fwd_data = dmld ? ld_data : aluout;
  end

  always_ff @(posedge clk) begin
    if (cm && dmstr) begin
      if (dmsel) mem[widx][{lane, 3'b000} +: 8] <= rfd2[7:0];
      else       mem[widx] <= rfd2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dmld_nxt   <= 1'b0;
      memout_nxt <= '0;
      aluout_nxt <= '0;
      pc_nxt     <= '0;
      IR_nxt     <= '0;
      misal_nxt  <= 1'b0;
    end else if (flush) begin
      dmld_nxt   <= 1'b0;
      memout_nxt <= '0;
      aluout_nxt <= '0;
      pc_nxt     <= '0;
      IR_nxt     <= '0;
      misal_nxt  <= 1'b0;
    end else if (en) begin
      dmld_nxt   <= is_ld;
      memout_nxt <= ld_data;
      aluout_nxt <= aluout;
      pc_nxt     <= pc;
      IR_nxt     <= IR;
      misal_nxt  <= misal;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_cnt <= '0;
      st_cnt <= '0;
    end else if (cm) begin
      if (is_ld) ld_cnt <= ld_cnt + 32'd1;
      if (dmstr) st_cnt <= st_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: byte-addressed reference memory, expected
// MEM/WB state queued per cycle and checked by an independent monitor.
module tb_mem_stage;

  localparam int unsigned DM_AW = 10;
  localparam int unsigned DEPTH = 1 << DM_AW;

  logic        clk = 1'b0;
  logic        rst, en, flush, dmld, dmsel, dmstr;
  logic [31:0] aluout, rfd2, pc, IR;
  logic [31:0] fwd_data, memout_nxt, aluout_nxt, pc_nxt, IR_nxt, ld_cnt, st_cnt;
  logic        dmld_nxt, misal_nxt;

  mem_stage #(.DM_AW(DM_AW)) dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .dmld(dmld), .dmsel(dmsel),
    .dmstr(dmstr), .aluout(aluout), .rfd2(rfd2), .pc(pc), .IR(IR),
    .fwd_data(fwd_data), .dmld_nxt(dmld_nxt), .memout_nxt(memout_nxt),
    .aluout_nxt(aluout_nxt), .pc_nxt(pc_nxt), .IR_nxt(IR_nxt),
    .misal_nxt(misal_nxt), .ld_cnt(ld_cnt), .st_cnt(st_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        dmld;
    logic [31:0] memout, alu, pc, ir;
    logic        mis;
    logic [31:0] ldc, stc;
  } exp_t;

  exp_t        cur;
  exp_t        q[$];
  logic [7:0]  bm [4*DEPTH];
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int unsigned byte_base(input logic [31:0] a);
    return ((a >> 2) % DEPTH) * 4;
  endfunction

  function automatic logic [31:0] mdl_load(input logic [31:0] a, input logic sel);
    int unsigned b;
    logic [7:0]  bt;
    b = byte_base(a);
    if (sel) begin
      bt = bm[b + a[1:0]];
      return {{24{bt[7]}}, bt};
    end
    return {bm[b+3], bm[b+2], bm[b+1], bm[b]};
  endfunction

  task automatic mdl_store(input logic [31:0] a, input logic sel, input logic [31:0] d);
    int unsigned b;
    b = byte_base(a);
    if (sel) bm[b + a[1:0]] = d[7:0];
    else for (int unsigned k = 0; k < 4; k++) bm[b + k] = d[8*k +: 8];
  endtask

  function automatic exp_t zero_regs(input exp_t e);
    exp_t r;
    r = e;
    r.dmld = 1'b0; r.memout = '0; r.alu = '0; r.pc = '0; r.ir = '0; r.mis = 1'b0;
    return r;
  endfunction

  // One instruction slot: drive after negedge, check forwarding, predict the post-edge state.
  task automatic step(input logic e, input logic f, input logic ld, input logic sel,
                      input logic st, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] ldv;
    logic        mis;
    @(negedge clk);
    en = e; flush = f; dmld = ld; dmsel = sel; dmstr = st;
    aluout = a; rfd2 = d; pc = $urandom; IR = $urandom;
    #1;
    ldv = (ld && !st) ? mdl_load(a, sel) : 32'd0;
    mis = (ld || st) && !sel && (a[1:0] != 2'b00);
    chk("fwd_data", fwd_data, ld ? ldv : a);
    if (f) cur = zero_regs(cur);
    else if (e) begin
      cur.dmld = ld && !st; cur.memout = ldv; cur.alu = a;
      cur.pc = pc; cur.ir = IR; cur.mis = mis;
    end
    if (e && !f) begin
      if (ld && !st) cur.ldc = cur.ldc + 32'd1;
      if (st) begin
        cur.stc = cur.stc + 32'd1;
        mdl_store(a, sel, d);
      end
    end
    q.push_back(cur);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_dmld"}, {31'd0, dmld_nxt}, 32'd0);
    chk({tag, "_memout"}, memout_nxt, 32'd0);
    chk({tag, "_aluout"}, aluout_nxt, 32'd0);
    chk({tag, "_pc"}, pc_nxt, 32'd0);
    chk({tag, "_IR"}, IR_nxt, 32'd0);
    chk({tag, "_misal"}, {31'd0, misal_nxt}, 32'd0);
    chk({tag, "_ld_cnt"}, ld_cnt, 32'd0);
    chk({tag, "_st_cnt"}, st_cnt, 32'd0);
  endtask

  always @(posedge clk) begin
    exp_t x;
    #1;
    if (q.size() > 0) begin
      x = q.pop_front();
      chk("dmld_nxt", {31'd0, dmld_nxt}, {31'd0, x.dmld});
      chk("memout_nxt", memout_nxt, x.memout);
      chk("aluout_nxt", aluout_nxt, x.alu);
      chk("pc_nxt", pc_nxt, x.pc);
      chk("IR_nxt", IR_nxt, x.ir);
      chk("misal_nxt", {31'd0, misal_nxt}, {31'd0, x.mis});
      chk("ld_cnt", ld_cnt, x.ldc);
      chk("st_cnt", st_cnt, x.stc);
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; flush = 1'b0; dmld = 1'b0; dmsel = 1'b0; dmstr = 1'b0;
    aluout = '0; rfd2 = '0; pc = '0; IR = '0;
    cur = zero_regs(cur); cur.ldc = '0; cur.stc = '0;
    #3;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int unsigned i = 0; i < DEPTH; i++) step(1, 0, 0, 0, 1, i * 4, $urandom);

    // word store then load
    step(1, 0, 0, 0, 1, 32'h10, 32'hDEADBEEF);
    step(1, 0, 1, 0, 0, 32'h10, 32'h0);
    @(posedge clk); #1;
    chk("t2_lw", memout_nxt, 32'hDEADBEEF);

    // byte lanes
    step(1, 0, 0, 0, 1, 32'h20, 32'h0);
    step(1, 0, 0, 1, 1, 32'h22, 32'h000000F0);
    step(1, 0, 1, 0, 0, 32'h20, 32'h0);
    @(posedge clk); #1;
    chk("t3_word", memout_nxt, 32'h00F00000);
    step(1, 0, 1, 1, 0, 32'h22, 32'h0);
    @(posedge clk); #1;
    chk("t3_lb22", memout_nxt, 32'hFFFFFFF0);
    step(1, 0, 1, 1, 0, 32'h21, 32'h0);
    @(posedge clk); #1;
    chk("t3_lb21", memout_nxt, 32'h00000000);

    // stall then commit; flushed store; flush while stalled
    repeat (3) step(0, 0, 0, 0, 1, 32'h30, 32'hA5A5A5A5);
    step(1, 0, 0, 0, 1, 32'h30, 32'hA5A5A5A5);
    step(1, 1, 0, 0, 1, 32'h30, 32'h11111111);
    step(1, 0, 1, 0, 0, 32'h30, 32'h0);
    step(0, 1, 1, 0, 0, 32'h30, 32'h0);
    step(1, 0, 1, 0, 0, 32'h30, 32'h0);

    // misalignment and address wrap
    step(1, 0, 1, 0, 0, 32'h13, 32'h0);
    @(posedge clk); #1;
    chk("t5_misal", {31'd0, misal_nxt}, 32'd1);
    step(1, 0, 0, 0, 1, (32'd4 << DM_AW) + 32'h10, 32'hCAFEF00D);
    step(1, 0, 1, 0, 0, 32'h10, 32'h0);
    @(posedge clk); #1;
    chk("t5_wrap", memout_nxt, 32'hCAFEF00D);

    // load+store conflict acts as store only
    step(1, 0, 1, 0, 1, 32'h40, 32'h77665544);
    step(1, 0, 1, 0, 0, 32'h40, 32'h0);

    // asynchronous reset mid-cycle with a store presented: dropped, memory retained
    @(negedge clk);
    #2;
    rst = 1'b1; en = 1'b1; flush = 1'b0; dmld = 1'b0; dmsel = 1'b0; dmstr = 1'b1;
    aluout = 32'h10; rfd2 = 32'h12345678;
    #1;
    chk_all_zero("midrst");
    cur = zero_regs(cur); cur.ldc = '0; cur.stc = '0;
    @(negedge clk);
    rst = 1'b0; en = 1'b0; dmstr = 1'b0;
    step(1, 0, 1, 0, 0, 32'h10, 32'h0);

    for (int unsigned i = 0; i < 600; i++) begin
      int unsigned op;
      op = $urandom_range(0, 7);
      step($urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0,
           op inside {1, 2, 3, 7}, $urandom_range(0, 1) == 1,
           op inside {4, 5, 6, 7}, $urandom, $urandom);
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
